tlc_phase_scheduler: RTL

//  Demand-driven phase scheduler for the 4-way junction light encoder.
//  - Latches vehicle-sensor and pedestrian-button demand.
//  - Grants green to one approach at a time in round-robin order (S->W->N->E).
//  - Enforces min/max green, yellow, all-red clearance and pedestrian walk timing.
//  - Drives registered per-approach green/yellow/red and walk signals to the lamp encoder.

---
 rtl/tlc_phase_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tlc_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a 4-way junction (S,W,N,E).
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
module tlc_phase_scheduler #(
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 15,
    parameter int YLW_TIME    = 2,
    parameter int ALLRED_TIME = 1,
    parameter int PED_TIME    = 5,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] veh_req,
    input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt_req,
    input  logic [1:0] preempt_dir,
`endif
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic       ped_walk,
    output logic       all_red
);

    typedef enum logic [1:0] {
        ST_ALL_RED  = 2'd0,
        ST_GREEN    = 2'd1,
        ST_YELLOW   = 2'd2,
        ST_PED_WALK = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YLW_LIM = CNT_W'(YLW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] PED_LIM = CNT_W'(PED_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pending_q, pending_d;
    logic             ped_pending_q, ped_pending_d;
    logic [3:0]       green_d, yellow_d, red_d;
    logic             ped_walk_d, all_red_d;
    logic [1:0]       pick_s;
    logic             any_s;
    logic             competing_s;
    logic             pre_s;
    logic [1:0]       pdir_s;

`ifdef EMERGENCY_PREEMPT_EN
    assign pre_s  = preempt_req;
    assign pdir_s = preempt_dir;
`else
    assign pre_s  = 1'b0;
    assign pdir_s = 2'd0;
`endif

    assign competing_s = ped_pending_q | (|(pending_q & ~dir_onehot(dir_q)));

    // Round-robin search: first pending approach at or after rr_q, circular
    always_comb begin
        pick_s = rr_q;
        any_s  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!any_s && pending_q[rr_q + 2'(k)]) begin
                pick_s = rr_q + 2'(k);
                any_s  = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    // Next-state, timer and demand-latch logic
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rr_d    = rr_q;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q >= AR_LIM) begin
                    if (pre_s) begin
                        state_d = ST_GREEN;
                        dir_d   = pdir_s;
                    end else if (ped_pending_q) begin
                        state_d = ST_PED_WALK;
                    end else if (any_s) begin
                        state_d = ST_GREEN;
                        dir_d   = pick_s;
                        rr_d    = pick_s + 2'd1;
                    end else begin
                        state_d = ST_ALL_RED;
                    end
                end else begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_GREEN: begin
                if (pre_s) begin
                    state_d = (pdir_s != dir_q) ? ST_YELLOW : ST_GREEN;
                end else if ((cnt_q >= MIN_LIM) && competing_s &&
                             (!veh_req[dir_q] || (cnt_q >= MAX_LIM))) begin
                    state_d = ST_YELLOW;
                end else begin
                    state_d = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                state_d = (cnt_q >= YLW_LIM) ? ST_ALL_RED : ST_YELLOW;
            end
            ST_PED_WALK: begin
                state_d = (pre_s || (cnt_q >= PED_LIM)) ? ST_ALL_RED : ST_PED_WALK;
            end
            default: begin
                state_d = ST_ALL_RED;
            end
        endcase

        cnt_d = (state_d != state_q) ? '0 :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        // The approach being granted loses its own request; others keep theirs
        pending_d = (pending_q | (veh_req & ~((state_q == ST_GREEN) ? dir_onehot(dir_q) : 4'b0000)))
                  & ~(((state_d == ST_GREEN) && (state_q != ST_GREEN)) ? dir_onehot(dir_d) : 4'b0000);
        ped_pending_d = (ped_pending_q | (ped_req & (state_q != ST_PED_WALK)))
                      & ~((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK));
    end

    // Lamp decode from next state so outputs change on the same edge as state
    always_comb begin
        green_d    = (state_d == ST_GREEN)  ? dir_onehot(dir_d) : 4'b0000;
        yellow_d   = (state_d == ST_YELLOW) ? dir_onehot(dir_d) : 4'b0000;
        red_d      = ~(green_d | yellow_d);
        ped_walk_d = (state_d == ST_PED_WALK);
        all_red_d  = (state_d == ST_ALL_RED) || (state_d == ST_PED_WALK);
    end

    // State, timer, demand and lamp registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ALL_RED;
            dir_q         <= 2'd0;
            rr_q          <= 2'd0;
            cnt_q         <= '0;
            pending_q     <= 4'b0000;
            ped_pending_q <= 1'b0;
            green         <= 4'b0000;
            yellow        <= 4'b0000;
            red           <= 4'b1111;
            ped_walk      <= 1'b0;
            all_red       <= 1'b1;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            ped_pending_q <= ped_pending_d;
            green         <= green_d;
            yellow        <= yellow_d;
            red           <= red_d;
            ped_walk      <= ped_walk_d;
            all_red       <= all_red_d;
        end
    end

endmodule
